// File: rtl/pixel_write_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pixel_write_ctrl
//
// Purpose:
//   Avalon-MM write master that drains a double-buffered pixel write buffer
//   into memory, one 24-bit pixel per 32-bit word. A frame is started with
//   base address and pixel count. The upstream buffer signals each loaded
//   group of GROUP_SIZE pixels with group_ready. The controller then issues
//   single writes with at most one outstanding. It waits for the write
//   response of each word before issuing the next one, because the buffer
//   shifts on that response.
//
// Parameters:
//   GROUP_SIZE  pixels per double-buffer half (words per group)
//   ADDR_STEP   byte address increment per written word
//
// Ports:
//   clk                        clock, rising edge
//   n_rst                      asynchronous active-low reset
//   start                      single-cycle frame start (accepted in IDLE only)
//   base_addr[31:0]            frame start byte address, sampled on start
//   pixel_count[19:0]          pixels in frame, sampled on start
//   group_ready                pulse: one more group loaded into the buffer
//   master_waitrequest         Avalon-MM slave stall
//   master_writeresponsevalid  Avalon-MM write response
//   master_write               Avalon-MM write request
//   master_address[31:0]       Avalon-MM byte address (held outside WRITE)
//   master_byteenable[3:0]     constant 4'b0111, pixel in the low three bytes
//   busy                       high whenever the FSM is not IDLE
//   frame_done                 single-cycle pulse at frame completion
//   overflow_err               sticky: group_ready arrived with two groups pending
//   timeout_err                sticky: response timeout (0 unless the option is built)
//
// Build option:
//   WRITE_TIMEOUT_EN  when defined, an 8-bit counter runs while waiting for a
//                     response. If it reaches 255, the frame is abandoned:
//                     timeout_err is set, the pending groups are dropped and
//                     the FSM returns to IDLE without frame_done. When the
//                     macro is undefined, RESP waits forever and timeout_err
//                     is tied low.
// -----------------------------------------------------------------------------
module pixel_write_ctrl #(
  parameter int GROUP_SIZE = 6,
  parameter int ADDR_STEP  = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [19:0] pixel_count,
  input  logic        group_ready,
  input  logic        master_waitrequest,
  input  logic        master_writeresponsevalid,
  output logic        master_write,
  output logic [31:0] master_address,
  output logic [3:0]  master_byteenable,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow_err,
  output logic        timeout_err
);

  localparam int              WC_W       = $clog2(GROUP_SIZE + 1);
  localparam logic [WC_W-1:0] GROUP_LAST = WC_W'(GROUP_SIZE);
  localparam logic [31:0]     STEP       = 32'(ADDR_STEP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;            // address of the next word to write
  logic [19:0]     remaining_q, remaining_d;  // words still to write in this frame
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;    // words written in the current group
  logic [1:0]      pending_q, pending_d;      // loaded groups not yet drained (0..2)
  logic [31:0]     maddr_q, maddr_d;          // registered bus address
  logic            overflow_q, overflow_d;

  // Decoded events from the FSM, consumed by the pending/error logic.
  logic            group_done;   // the response just taken finishes a group
  logic            clear_err;    // a start was accepted this cycle
  logic            timeout_hit;  // response wait gave up this cycle

  // Intermediate values of the response update; the completion decision is
  // made on the values after the update.
  logic [WC_W-1:0] word_cnt_inc;
  logic [19:0]     remaining_dec;
  logic [31:0]     addr_inc;

`ifdef WRITE_TIMEOUT_EN
  logic [7:0]      tmo_q, tmo_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      word_cnt_q  <= '0;
      pending_q   <= '0;
      maddr_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      word_cnt_q  <= word_cnt_d;
      pending_q   <= pending_d;
      maddr_q     <= maddr_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef WRITE_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    word_cnt_d    = word_cnt_q;
    maddr_d       = maddr_q;
    group_done    = 1'b0;
    clear_err     = 1'b0;
    timeout_hit   = 1'b0;
    word_cnt_inc  = word_cnt_q + 1'b1;
    remaining_dec = remaining_q - 20'd1;
    addr_inc      = addr_q + STEP;  // wraps modulo 2^32 by construction
`ifdef WRITE_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = pixel_count;
          clear_err   = 1'b1;
          state_d     = (pixel_count == 20'd0) ? DONE : ARM;
        end
      end

      ARM: begin
        // Only issue a write once a loaded group is in the buffer.
        if (pending_q != 2'd0) begin
          word_cnt_d = '0;
          maddr_d    = addr_q;
          state_d    = WRITE;
        end
      end

      WRITE: begin
        if (!master_waitrequest) begin
          state_d = RESP;
`ifdef WRITE_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end

      RESP: begin
        if (master_writeresponsevalid) begin
          addr_d      = addr_inc;
          word_cnt_d  = word_cnt_inc;
          remaining_d = remaining_dec;
          // A short final group ends when the frame runs out of pixels.
          if ((word_cnt_inc == GROUP_LAST) || (remaining_dec == 20'd0)) begin
            group_done = 1'b1;
            state_d    = (remaining_dec == 20'd0) ? DONE : ARM;
          end else begin
            maddr_d = addr_inc;
            state_d = WRITE;
          end
        end else begin
`ifdef WRITE_TIMEOUT_EN
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == 8'd254) begin
            // 255th cycle without a response: abandon the frame.
            timeout_hit = 1'b1;
            state_d     = IDLE;
          end
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending-group counter and sticky overflow. group_ready is counted in every
  // state so that groups loaded ahead of start are not lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (clear_err) begin
      overflow_d = 1'b0;
    end
    // The set wins over the start-time clear.
    if (group_ready && (pending_q == 2'd2)) begin
      overflow_d = 1'b1;
    end

    if (group_ready && !group_done) begin
      if (pending_q != 2'd2) begin
        pending_d = pending_q + 2'd1;
      end
    end else if (group_done && !group_ready) begin
      if (pending_q != 2'd0) begin
        pending_d = pending_q - 2'd1;
      end
    end

    // An abandoned frame leaves nothing in the buffer worth draining.
    if (timeout_hit) begin
      pending_d = 2'd0;
    end
  end

`ifdef WRITE_TIMEOUT_EN
  always_comb begin
    timeout_err_d = timeout_err_q;
    if (clear_err) begin
      timeout_err_d = 1'b0;
    end
    if (timeout_hit) begin
      timeout_err_d = 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign master_write      = (state_q == WRITE);
  assign master_address    = maddr_q;
  assign master_byteenable = 4'b0111;
  assign busy              = (state_q != IDLE);
  assign frame_done        = (state_q == DONE);
  assign overflow_err      = overflow_q;

endmodule

// File: tb/tb_pixel_write_ctrl.sv
`timescale 1ns/1ps
module tb_pixel_write_ctrl;

  localparam logic [31:0] STEP = 32'd4;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [31:0] base_addr;
  logic [19:0] pixel_count;
  logic        group_ready;
  logic        master_waitrequest;
  logic        master_writeresponsevalid;
  logic        master_write;
  logic [31:0] master_address;
  logic [3:0]  master_byteenable;
  logic        busy;
  logic        frame_done;
  logic        overflow_err;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  // Slave model state.
  logic [31:0] wlog [64];
  int          hlog [64];
  int          wcount      = 0;
  int          fdone       = 0;
  int          resp_cnt    = 0;
  int          resp_cd     = 0;
  int          resp_delay  = 2;
  bit          resp_en     = 1'b1;
  bit          inject_resp = 1'b0;
  int          stall_left  = 0;
  int          hold        = 0;
  logic [31:0] hold_addr   = '0;
  int          addr_chg    = 0;

  pixel_write_ctrl dut (
    .clk                       (clk),
    .n_rst                     (n_rst),
    .start                     (start),
    .base_addr                 (base_addr),
    .pixel_count               (pixel_count),
    .group_ready               (group_ready),
    .master_waitrequest        (master_waitrequest),
    .master_writeresponsevalid (master_writeresponsevalid),
    .master_write              (master_write),
    .master_address            (master_address),
    .master_byteenable         (master_byteenable),
    .busy                      (busy),
    .frame_done                (frame_done),
    .overflow_err              (overflow_err),
    .timeout_err               (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Avalon slave: drives waitrequest/response on the falling edge, logs every
  // accepted write and how many cycles its request was held.
  initial begin
    master_waitrequest        = 1'b0;
    master_writeresponsevalid = 1'b0;
    forever begin
      @(negedge clk);
      master_writeresponsevalid = 1'b0;
      if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0 && resp_en) begin
          master_writeresponsevalid = 1'b1;
          resp_cnt++;
        end
      end
      if (inject_resp) begin
        master_writeresponsevalid = 1'b1;
        inject_resp = 1'b0;
      end
      if (master_write) begin
        if (hold == 0) hold_addr = master_address;
        else if (master_address != hold_addr) addr_chg++;
        hold++;
        if (stall_left > 0) begin
          master_waitrequest = 1'b1;
          stall_left--;
        end else begin
          master_waitrequest = 1'b0;
          if (wcount < 64) begin
            wlog[wcount] = master_address;
            hlog[wcount] = hold;
          end
          wcount++;
          hold    = 0;
          resp_cd = resp_delay;
        end
      end else begin
        master_waitrequest = 1'b0;
      end
      if (frame_done) fdone++;
    end
  end

  task automatic clear_log();
    wcount   = 0;
    fdone    = 0;
    resp_cnt = 0;
    addr_chg = 0;
    hold     = 0;
  endtask

  task automatic start_frame(input logic [31:0] b, input logic [19:0] n);
    base_addr   = b;
    pixel_count = n;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic pulse_group();
    group_ready = 1'b1;
    @(negedge clk);
    group_ready = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i;
    i = 0;
    while (busy && i < max) begin
      @(negedge clk);
      i++;
    end
    chk("frame_end_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input logic [31:0] b, input int n);
    $display("frame base=%h n=%0d writes=%0d done=%0d", b, n, wcount, fdone);
    chk("write_count", 32'(wcount), 32'(n));
    chk("frame_done_count", 32'(fdone), 32'd1);
    for (int i = 0; i < n && i < 64; i++) begin
      chk("addr", wlog[i], b + STEP * 32'(i));
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_write", 32'(master_write), 32'd0);
    chk("rst_address", master_address, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow_err), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_byteenable", 32'(master_byteenable), 32'h7);
  endtask

  initial begin
    n_rst       = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    pixel_count = '0;
    group_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    n_rst = 1'b1;
    @(negedge clk);

    // Single full group.
    clear_log();
    start_frame(32'h0000_1000, 20'd6);
    pulse_group();
    wait_idle(200);
    check_frame(32'h0000_1000, 6);

    // Pending must be back at 0: a new frame waits in ARM until a group
    // arrives, and a stray response there is ignored.
    clear_log();
    start_frame(32'h0000_6000, 20'd1);
    repeat (10) @(negedge clk);
    inject_resp = 1'b1;
    repeat (3) @(negedge clk);
    chk("arm_wait_busy", 32'(busy), 32'd1);
    chk("arm_wait_writes", 32'(wcount), 32'd0);
    pulse_group();
    wait_idle(200);
    check_frame(32'h0000_6000, 1);

    // Three back-to-back groups: third one overflows.
    clear_log();
    base_addr   = 32'h0000_2000;
    pixel_count = 20'd12;
    start       = 1'b1;
    group_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ovf_after_first", 32'(overflow_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    group_ready = 1'b0;
    chk("ovf_set", 32'(overflow_err), 32'd1);
    wait_idle(400);
    check_frame(32'h0000_2000, 12);
    chk("ovf_sticky", 32'(overflow_err), 32'd1);

    // Stalled first write; start also clears the sticky overflow.
    clear_log();
    stall_left = 5;
    start_frame(32'h0000_1000, 20'd6);
    chk("ovf_clear", 32'(overflow_err), 32'd0);
    pulse_group();
    wait_idle(300);
    check_frame(32'h0000_1000, 6);
    chk("stall_hold", 32'(hlog[0]), 32'd6);
    chk("nostall_hold", 32'(hlog[1]), 32'd1);
    chk("stall_addr_const", 32'(addr_chg), 32'd0);

    // Eight pixels over two groups; a start mid-frame is ignored.
    clear_log();
    start_frame(32'h0000_3000, 20'd8);
    pulse_group();
    pulse_group();
    repeat (4) @(negedge clk);
    start_frame(32'h0000_9000, 20'd3);
    wait_idle(400);
    check_frame(32'h0000_3000, 8);

    // Address wraps through 2^32.
    clear_log();
    start_frame(32'hFFFF_FFFC, 20'd2);
    pulse_group();
    wait_idle(200);
    check_frame(32'hFFFF_FFFC, 2);

    // Empty frame: straight to DONE.
    clear_log();
    start_frame(32'h0000_7000, 20'd0);
    wait_idle(20);
    check_frame(32'h0000_7000, 0);

    // Reset after the third response, then a clean frame from a new base.
    clear_log();
    start_frame(32'h0000_4000, 20'd6);
    pulse_group();
    for (int i = 0; i < 200 && resp_cnt < 3; i++) @(negedge clk);
    chk("resp_before_reset", 32'(resp_cnt), 32'd3);
    @(posedge clk);
    #2;
    n_rst   = 1'b0;
    resp_cd = 0;
    @(negedge clk);
    check_reset_outputs();
    chk("no_done_on_abort", 32'(fdone), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    clear_log();
    start_frame(32'h0000_5000, 20'd6);
    pulse_group();
    wait_idle(200);
    check_frame(32'h0000_5000, 6);

`ifdef WRITE_TIMEOUT_EN
    // No response to the first write: give up after 255 RESP cycles.
    clear_log();
    resp_en = 1'b0;
    start_frame(32'h0000_8000, 20'd2);
    pulse_group();
    wait_idle(600);
    $display("timeout frame writes=%0d done=%0d", wcount, fdone);
    chk("timeout_err", 32'(timeout_err), 32'd1);
    chk("timeout_no_done", 32'(fdone), 32'd0);
    chk("timeout_writes", 32'(wcount), 32'd1);
    resp_en = 1'b1;
    resp_cd = 0;
`else
    chk("timeout_tied", 32'(timeout_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/pixel_write_ctrl.md
PIXEL_WRITE_CTRL -- requirements
Module: pixel_write_ctrl

Interface
REQ-001 Parameter GROUP_SIZE, default 6, meaning pixels per double-buffer half (words per group).
REQ-002 Parameter ADDR_STEP, default 4, meaning byte address increment per written word.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle frame start request.
REQ-006 base_addr  input  32  frame start byte address, sampled on accepted start.
REQ-007 pixel_count  input  20  pixels in frame, sampled on accepted start.
REQ-008 group_ready  input  1  single-cycle pulse: write buffer has loaded one full group.
REQ-009 master_waitrequest  input  1  Avalon-MM slave stall.
REQ-010 master_writeresponsevalid  input  1  Avalon-MM write response; write buffer shifts on it.
REQ-011 master_write  output  1  Avalon-MM write request.
REQ-012 master_address  output  32  Avalon-MM byte address.
REQ-013 master_byteenable  output  4  fixed 4'b0111 (24-bit pixel in low bytes).
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 frame_done  output  1  single-cycle pulse at frame completion.
REQ-016 overflow_err  output  1  sticky: group_ready arrived with 2 groups already pending.
REQ-017 timeout_err  output  1  sticky response-timeout flag (see Configuration).

Function
REQ-018 FSM states IDLE, ARM, WRITE, RESP, DONE; no other reachable states.
REQ-019 IDLE: start accepted -> load addr=base_addr, remaining=pixel_count, clear both sticky errors; go ARM, or DONE if pixel_count==0.
REQ-020 start outside IDLE SHALL be ignored with no state change.
REQ-021 pending counter 0..2: +1 on group_ready, -1 on group completion; both same cycle -> unchanged.
REQ-022 group_ready with pending==2 -> overflow_err set, pending stays 2.
REQ-023 group_ready is counted in every state, including IDLE.
REQ-024 ARM: pending>0 -> WRITE with word_cnt=0; else hold ARM.
REQ-025 WRITE: master_write=1, master_address=addr; stays while master_waitrequest=1; on master_waitrequest=0 -> RESP next cycle.
REQ-026 master_write SHALL be 0 in every state except WRITE; one outstanding write maximum.
REQ-027 RESP: on master_writeresponsevalid -> addr+=ADDR_STEP, word_cnt+=1, remaining-=1.
REQ-028 After a response, word_cnt==GROUP_SIZE or remaining==0 -> group complete (pending-=1); then remaining==0 -> DONE, else ARM.
REQ-029 After a response without group completion -> WRITE.
REQ-030 master_writeresponsevalid outside RESP SHALL be ignored.
REQ-031 DONE: frame_done=1 for exactly one cycle -> IDLE.
REQ-032 Address arithmetic is 32-bit modulo 2^32; wrap is not flagged.
REQ-033 master_address SHALL hold its last value outside WRITE.

Reset
REQ-034 n_rst low -> state IDLE, addr=0, remaining=0, word_cnt=0, pending=0, timeout counter=0.
REQ-035 Reset values: master_write=0, master_address=0, busy=0, frame_done=0, overflow_err=0, timeout_err=0; master_byteenable=4'b0111.
REQ-036 Reset mid-frame aborts immediately; no frame_done is issued.

Configuration
REQ-037 Macro WRITE_TIMEOUT_EN defined: 8-bit counter clears on RESP entry, increments each RESP cycle without response; at 255 -> timeout_err=1, pending=0, go IDLE without frame_done.
REQ-038 Macro WRITE_TIMEOUT_EN undefined: no counter; timeout_err tied 0; RESP waits indefinitely.

Verification
REQ-039 start, base_addr=0x1000, pixel_count=6, one group_ready, waitrequest=0, response 2 cycles after each write -> addresses 0x1000..0x1014 step 4, six writes, one frame_done, pending ends 0.
REQ-040 pixel_count=12, group_ready x3 back-to-back before any write -> overflow_err=1 on third pulse, pending=2, frame still completes with 12 writes.
REQ-041 waitrequest=1 for 5 cycles on first write -> master_write held 6 cycles with address constant 0x1000; no RESP until accept.
REQ-042 pixel_count=8, two group_ready -> writes at base+0..base+28, second group completes after 2 words, frame_done once.
REQ-043 WRITE_TIMEOUT_EN defined, no response after first write -> timeout_err=1 after 255 RESP cycles, busy=0, frame_done never asserted.
REQ-044 n_rst pulsed low after 3rd response of a 6-pixel frame -> all outputs at reset values; subsequent start with pixel_count=6 writes from new base_addr correctly.
